oscillator: RTL

OSCILLATOR -- requirements
Module: oscillator

---
 rtl/oscillator_if.sv | 27 ++
 rtl/oscillator.sv | 92 +++++++++
 2 files changed

// File: rtl/oscillator_if.sv
// Oscillator control/sample bus: the controller drives enable, frequency and
// waveform selection; the oscillator returns the sample and its strobe.
interface oscillator_if;
    logic       en;
    logic [15:0] freq_word;
    logic [1:0]  wave_sel;
    logic [7:0]  sample;
    logic        sample_stb;

    // Controller side (testbench or upstream sequencer)
    modport master (
        output en,
        output freq_word,
        output wave_sel,
        input  sample,
        input  sample_stb
    );

    // Oscillator side
    modport slave (
        input  en,
        input  freq_word,
        input  wave_sel,
        output sample,
        output sample_stb
    );
endinterface : oscillator_if

// File: rtl/oscillator.sv
// Frame-rate waveform oscillator. A 256-cycle frame counter paces a 16-bit
// phase accumulator; at each frame boundary a new 8-bit sample (square, saw,
// triangle or noise/silence) is loaded and strobed for one cycle.
// Optional feature macro: OSC_NOISE_EN adds a 16-bit Fibonacci LFSR that
// drives wave_sel=11; without it wave_sel=11 is silent.
module oscillator (
    input  logic         clk,
    input  logic         nrst,
    oscillator_if.slave  osc
);
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned PHASE_W  = 16;
    localparam int unsigned SAMPLE_W = 8;

    localparam logic [1:0] SEL_SQUARE   = 2'b00;
    localparam logic [1:0] SEL_SAW      = 2'b01;
    localparam logic [1:0] SEL_TRIANGLE = 2'b10;

    logic [CNT_W-1:0]    frame_cnt;
    logic [PHASE_W-1:0]  phase;
    logic [SAMPLE_W-1:0] sample_q;
    logic                stb_q;

    logic                update_c;
    logic [PHASE_W-1:0]  phase_next_c;
    logic [SAMPLE_W-1:0] sample_next_c;

`ifdef OSC_NOISE_EN
    localparam logic [PHASE_W-1:0] LFSR_SEED = 16'hACE1;

    logic [PHASE_W-1:0] lfsr;
    logic [PHASE_W-1:0] lfsr_next_c;

    // Fibonacci step, taps 16/14/13/11
    always_comb begin
        lfsr_next_c = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // LFSR advances only at frame-boundary update edges
    always_ff @(posedge clk) begin
        if (!nrst) begin
            lfsr <= LFSR_SEED;
        end else if (update_c) begin
            lfsr <= lfsr_next_c;
        end
    end
`endif

    // Frame boundary detection, next phase and waveform mapping of the next phase
    always_comb begin
        update_c      = osc.en && (frame_cnt == {CNT_W{1'b1}});
        phase_next_c  = phase + osc.freq_word;
        sample_next_c = '0;
        case (osc.wave_sel)
            SEL_SQUARE:   sample_next_c = phase_next_c[15] ? 8'hFF : 8'h00;
            SEL_SAW:      sample_next_c = phase_next_c[15:8];
            SEL_TRIANGLE: sample_next_c = phase_next_c[15] ? ~{phase_next_c[14:8], 1'b0}
                                                           :  {phase_next_c[14:8], 1'b0};
            default: begin
`ifdef OSC_NOISE_EN
                sample_next_c = lfsr_next_c[15:8];
`else
                sample_next_c = '0;
`endif
            end
        endcase
    end

    // Frame counter, phase, sample and strobe; en=0 freezes everything but the strobe
    always_ff @(posedge clk) begin
        if (!nrst) begin
            frame_cnt <= '0;
            phase     <= '0;
            sample_q  <= '0;
            stb_q     <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            if (osc.en) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                if (update_c) begin
                    phase    <= phase_next_c;
                    sample_q <= sample_next_c;
                    stb_q    <= 1'b1;
                end
            end
        end
    end

    assign osc.sample     = sample_q;
    assign osc.sample_stb = stb_q;

endmodule : oscillator
